sub_kgp_pipe: RTL and testbench
===============================

// Module: sub_kgp_pipe
// PURPOSE
//  Two-stage pipelined WIDTH-bit subtractor, the inverse companion of the KGP carry-chain adder.
//  Computes diff = a - b as a + ~b + 1. The carry chain is seeded with GENERATE (2'b11) instead of KILL (2'b00).
//  Sits in the ALU lane of the VLIW execute slot. Uses a valid/ready handshake with full backpressure.
// PARAMETERS
//  WIDTH  64  operand width; must be even; the chain is split at WIDTH/2 across the two stages
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands present on a/b
//  in_ready   out  1      unit can accept a/b this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      result fields valid
//  out_ready  in   1      downstream accepts the result this cycle
//  diff       out  WIDTH  a - b, modulo 2^WIDTH
//  borrow     out  1      1 when unsigned a < b (inverse of the final carry-out)
//  ovf        out  1      signed overflow: a[MSB] != b[MSB] && diff[MSB] != a[MSB]
//  zero       out  1      diff == 0
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low.
//  Reset (rst_n==0 at posedge): both stage valids cleared, out_valid=0, diff=0, borrow=0, ovf=0, zero=0.
//   Any operation in flight is dropped; no partial result ever appears.
//  KGP encoding per bit i: {a_i, ~b_i}. 00 = kill, 11 = generate, 01/10 = propagate.
//   Combine rule: propagate passes the lower carry status through; kill or generate overrides it.
//  Stage 1 (S1), registered at accept:
//   - latch a, ~b;
//   - resolve carries for bits [WIDTH/2-1:0] from the seed 2'b11;
//   - register the low-half sum and the carry status into bit WIDTH/2.
//  Stage 2 (S2):
//   - resolve carries for the high half from the registered mid carry;
//   - form diff, carry-out, borrow=~carry-out, ovf, zero;
//   - register all result outputs.
//  Latency: 2 cycles from in_valid&&in_ready to out_valid. Throughput: 1 result per cycle when not stalled.
//  Handshake:
//   - advance = ~s2_valid | out_ready;
//   - S2 loads from S1 when advance;
//   - S1 loads when in_ready;
//   - in_ready = ~s1_valid | advance (combinational, no skid buffer).
//   - A transfer occurs on valid&&ready at the posedge.
//  Stall rules:
//   - while out_valid && !out_ready, diff/borrow/ovf/zero/out_valid hold stable;
//   - when S1 is also full, in_ready=0.
//  Simultaneous events: the pipe is full, out_ready=1 and in_valid=1 in the same cycle.
//   S2 takes S1, S1 takes the new operands, and the result is consumed; nothing is lost or duplicated.
//  Bubbles: S1 empty while advance=1 -> s2_valid clears at that edge; the data regs may hold stale values.
//  Boundaries:
//   - a==b gives diff=0, zero=1, borrow=0.
//   - Wrap-around is modulo; there is no saturation.
//   - in_valid without an accepting in_ready has no effect.
// TESTING
//  1. a=5, b=3, out_ready=1 -> 2 cycles later diff=2, borrow=0, ovf=0, zero=0.
//  2. a=0, b=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0, zero=0.
//     This case exercises full-length borrow propagation across the stage split.
//  3. a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, borrow=0.
//     Also a=b=64'hDEAD_BEEF_0000_0001 -> zero=1, borrow=0.
//  4. Stream 4 back-to-back ops with out_ready held 0 for 3 cycles after the first result.
//     -> in_ready drops once both stages are full; outputs stay stable during the stall;
//     -> all 4 results emerge in order with no loss.
//  5. Pipe full, then in_valid=1 and out_ready=1 in the same cycle.
//     -> one result consumed, one op accepted, out_valid stays 1 on the next cycle.
//  6. rst_n=0 for 1 cycle while 2 ops are in flight -> next cycle out_valid=0 and all outputs are 0.
//     -> the first op issued after reset returns its correct result at latency 2.

Source files
------------

// File: rtl/sub_kgp_pipe.sv
// Two-stage pipelined subtractor: diff = a + ~b + 1 via a KGP carry chain seeded with GENERATE.
// The chain is split at WIDTH/2; valid/ready handshake with full backpressure, no skid buffer.
module sub_kgp_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int HALF = WIDTH / 2;
   localparam logic [1:0] KGP_GENERATE = 2'b11;

   // Ripples a carry status through one half; returns {final status, sum bits}.
   // Equal bits kill (00) or generate (11) and override; unequal bits propagate.
   function automatic logic [HALF+1:0] kgp_chain(input logic [HALF-1:0] x,
                                                 input logic [HALF-1:0] y,
                                                 input logic [1:0]      seed);
      logic [1:0]      status;
      logic [HALF-1:0] sum;
      status = seed;
      sum    = '0;
      for (int i = 0; i < HALF; i++) begin
         sum[i] = x[i] ^ y[i] ^ (status == KGP_GENERATE);
         if (x[i] == y[i]) status = {x[i], y[i]};
      end
      return {status, sum};
   endfunction

   logic            s1_valid;
   logic [HALF-1:0] s1_a_hi;
   logic [HALF-1:0] s1_nb_hi;
   logic [HALF-1:0] s1_sum_lo;
   logic [1:0]      s1_mid;

   logic             advance;
   logic [HALF+1:0]  lo_res;
   logic [HALF+1:0]  hi_res;
   logic [WIDTH-1:0] diff_next;
   logic             cout_next;
   logic             ovf_next;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | advance;

   always_comb begin
      lo_res    = kgp_chain(a[HALF-1:0], ~b[HALF-1:0], KGP_GENERATE);
      hi_res    = kgp_chain(s1_a_hi, s1_nb_hi, s1_mid);
      diff_next = {hi_res[HALF-1:0], s1_sum_lo};
      cout_next = (hi_res[HALF+1:HALF] == KGP_GENERATE);
      // Operand signs differ exactly when a's MSB equals the inverted b MSB.
      ovf_next  = (s1_a_hi[HALF-1] == s1_nb_hi[HALF-1]) &&
                  (diff_next[WIDTH-1] != s1_a_hi[HALF-1]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a_hi   <= '0;
         s1_nb_hi  <= '0;
         s1_sum_lo <= '0;
         s1_mid    <= '0;
         out_valid <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a_hi   <= a[WIDTH-1:HALF];
               s1_nb_hi  <= ~b[WIDTH-1:HALF];
               s1_sum_lo <= lo_res[HALF-1:0];
               s1_mid    <= lo_res[HALF+1:HALF];
            end
         end
         // A bubble clears out_valid but leaves the stale result fields in place.
         if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               diff   <= diff_next;
               borrow <= ~cout_next;
               ovf    <= ovf_next;
               zero   <= (diff_next == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_sub_kgp_pipe.sv
// Scoreboard bench for sub_kgp_pipe: accepted operands push an arithmetic reference result,
// a negedge monitor compares every presented output against the queue head.
module tb_sub_kgp_pipe;

   typedef struct packed {
      logic [63:0] diff;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } result_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        borrow;
   logic        ovf;
   logic        zero;

   result_t scoreboard[$];
   int      assertCount = 0;
   int      failCount   = 0;
   bit      randDone    = 0;

   sub_kgp_pipe #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic result_t refModel(input logic [63:0] x, input logic [63:0] y);
      result_t r;
      r.diff   = x - y;
      r.borrow = (x < y);
      r.ovf    = (x[63] != y[63]) && (r.diff[63] != x[63]);
      r.zero   = (x == y);
      return r;
   endfunction

   function automatic logic [63:0] randVal();
      case ($urandom_range(0, 5))
         0:       return 64'h0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'({$urandom_range(0, 3)});
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   // Offers one operand pair and returns just after the posedge that accepts it.
   task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      #1;
      while (!in_ready && waitCycles < 50) begin
         @(negedge clk);
         #1;
         waitCycles++;
      end
      if (!in_ready) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waitCycles);
      end else begin
         scoreboard.push_back(refModel(av, bv));
      end
      @(posedge clk);
   endtask

   task automatic checkLatency(input string tag);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkBit({tag, "_lat1_out_valid"}, out_valid, 1'b0);
      @(negedge clk);
      #1;
      checkBit({tag, "_lat2_out_valid"}, out_valid, 1'b1);
   endtask

   task automatic drain();
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (scoreboard.size() != 0 && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      @(negedge clk);
      assertCount++;
      if (scoreboard.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", scoreboard.size());
      end
   endtask

   // Monitor: compares every presented result to the queue head, pops on transfer.
   initial begin
      result_t expResult;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && out_valid) begin
            if (scoreboard.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_result: got diff %h with empty scoreboard, expected no out_valid", diff);
            end else begin
               expResult = scoreboard[0];
               checkOutput("diff", diff, expResult.diff);
               checkBit("borrow", borrow, expResult.borrow);
               checkBit("ovf", ovf, expResult.ovf);
               checkBit("zero", zero, expResult.zero);
               if (out_ready) void'(scoreboard.pop_front());
            end
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      checkBit("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_diff", diff, 64'h0);
      checkBit("rst_borrow", borrow, 1'b0);
      checkBit("rst_ovf", ovf, 1'b0);
      checkBit("rst_zero", zero, 1'b0);
      checkBit("rst_in_ready", in_ready, 1'b1);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      $display("[TB] directed basic cases");
      applyStimulus(64'd5, 64'd3);
      checkLatency("basic");
      applyStimulus(64'd0, 64'd1);
      applyStimulus(64'h8000_0000_0000_0000, 64'd1);
      applyStimulus(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
      applyStimulus(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001);
      applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      drain();

      $display("[TB] stream with output stall");
      fork
         begin : streamDriver
            for (int k = 0; k < 4; k++) applyStimulus(randVal(), randVal());
         end
         begin : stallControl
            int cyc;
            cyc = 0;
            do begin
               @(negedge clk);
               cyc++;
            end while (!out_valid && cyc < 20);
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               checkBit("stall_in_ready", in_ready, 1'b0);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("[TB] full pipe with simultaneous accept and consume");
      out_ready = 1'b0;
      applyStimulus(64'd100, 64'd58);
      applyStimulus(64'd7, 64'd9);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkBit("full_in_ready", in_ready, 1'b0);
      a         = 64'h1234_5678_9ABC_DEF0;
      b         = 64'h0FED_CBA9_8765_4321;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checkBit("simul_in_ready", in_ready, 1'b1);
      scoreboard.push_back(refModel(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkBit("simul_out_valid", out_valid, 1'b1);
      drain();

      $display("[TB] reset with operations in flight");
      applyStimulus(64'd40, 64'd2);
      applyStimulus(64'd11, 64'd22);
      @(negedge clk);
      in_valid  = 1'b0;
      rst_n     = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      scoreboard.delete();
      #1;
      checkBit("flush_out_valid", out_valid, 1'b0);
      checkOutput("flush_diff", diff, 64'h0);
      checkBit("flush_borrow", borrow, 1'b0);
      checkBit("flush_ovf", ovf, 1'b0);
      checkBit("flush_zero", zero, 1'b0);
      out_ready = 1'b1;
      applyStimulus(64'd1000, 64'd1);
      checkLatency("post_reset");
      drain();

      $display("[TB] randomized traffic with random backpressure");
      fork
         begin : randDriver
            logic [63:0] av;
            logic [63:0] bv;
            for (int k = 0; k < 200; k++) begin
               av = randVal();
               bv = ($urandom_range(0, 7) == 0) ? av : randVal();
               applyStimulus(av, bv);
               if ($urandom_range(0, 4) == 0) begin
                  @(negedge clk);
                  in_valid = 1'b0;
               end
            end
            randDone = 1'b1;
         end
         begin : readyToggler
            while (!randDone) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
